serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor that computes diff = a - b, one bit per clock, LSB first. It reports a borrow-out (unsigned a < b) and a signed overflow flag. It uses a start/ready/done handshake and serves as the low-area, multi-cycle subtract path beside the team's ripple-carry adder datapath.

Parameters:
WIDTH, 4, operand and result width in bits; must be >= 2.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted on a clk edge when ready=1
a  input  WIDTH  minuend, two's complement; sampled only on the accepting edge
b  input  WIDTH  subtrahend, two's complement; sampled only on the accepting edge
ready  output  1  high when a start will be accepted (IDLE or DONE)
diff  output  WIDTH  a - b modulo 2^WIDTH; valid from done onward
borrowout  output  1  1 iff unsigned a < unsigned b
overflow  output  1  signed result out of range
done  output  1  one-cycle pulse: result just became valid

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, shift registers=0, bit counter=0, internal carry=1.
  - Outputs: diff=0, borrowout=0, overflow=0, done=0, ready=1.
  - Reset mid-RUN aborts the operation silently. No done is produced and outputs read 0.
- States:
  - IDLE: ready=1. start=1 -> RUN. Latch a and b into shift regs, carry=1, counter=0.
  - RUN: ready=0, start ignored. Each edge:
    - diff bit = a_lsb XOR ~b_lsb XOR carry.
    - carry = majority(a_lsb, ~b_lsb, carry).
    - Shift result bit in at the MSB; shift a and b right; counter+1.
    - On the edge that processes bit WIDTH-1 -> DONE.
  - DONE: ready=1, done=1 for exactly this cycle. start=1 -> RUN (back-to-back, same latching as IDLE); otherwise -> IDLE.
- Latency: start accepted at edge E0. done is high in the cycle after edge E0+WIDTH (WIDTH=4: done follows the 4th edge after acceptance). Throughput is one result per WIDTH+1 cycles; back-to-back issue is taken in the DONE cycle.
- Arithmetic (a + ~b + 1):
  - borrowout = NOT final carry.
  - overflow = (a[MSB] != b[MSB]) AND (diff[MSB] != a[MSB]). Compute it from the latched a/b sign bits captured at start, not from the live inputs.
- Output holding:
  - diff, borrowout and overflow are registered. They update only when the DONE transition occurs.
  - They hold their value through IDLE and through a following RUN until the next DONE.
  - The intermediate shift-register contents are never visible on diff.
- Input sampling: a and b may change freely after the accepting edge without effect.
- Boundaries:
  - b=0: borrowout=0, overflow=0.
  - a=b: diff=0, borrowout=0.
  - a=MIN, b=1: overflow=1.
  - a=0, b=MIN: diff=MIN, borrowout=1, overflow=1.
- No X propagation: every register must be explicitly reset.

Decomposition:
- Shared package (sub_pkg):
  - State encoding constants: IDLE=2'b00, RUN=2'b01, DONE=2'b10; the 2'b11 encoding recovers to IDLE.
  - Default WIDTH.
  - Counter width $clog2(WIDTH).
- One sub-module: serial_sub_cell, a combinational 1-bit full subtractor (a, b, carry_in -> d, carry_out) built from gate primitives, each gate with the standard #50 delay macro.
- The FSM, counter, shift registers and result registers live in serial_subtractor.

Test Plan:
- a=0101, b=0011, start pulse -> done after 4 edges; diff=0010, borrowout=0, overflow=0, ready low during RUN.
- a=0011, b=0101 -> diff=1110, borrowout=1, overflow=0. a=0111, b=1000 -> diff=1111, borrowout=1, overflow=1.
- a=1000, b=0001 -> diff=0111, borrowout=0, overflow=1. Change a and b on the cycle after acceptance; the result is unchanged.
- Hold start=1 continuously with new operands each DONE cycle -> a done pulse every 5 cycles, each result correct. Also hold start high during RUN -> no restart and no extra done.
- Assert rst_n=0 at the 2nd RUN edge -> ready=1, diff=0, no done. A fresh start of 0000-0000 -> diff=0000, borrowout=0, overflow=0.
- Random sweep of all 256 a/b pairs at WIDTH=4, checked against the behavioural model (a-b, unsigned compare, signed range).

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// State encoding is fixed so the unused 2'b11 code has a defined recovery.
package sub_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_cell.sv
// One-bit full subtractor slice: computes a + ~b + cin from gate primitives.
// SUB_GATE_DLY lets gate-level simulation add a per-gate delay; it is empty by default.
`ifndef SUB_GATE_DLY
`define SUB_GATE_DLY
`endif

module serial_sub_cell (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic d,
  output logic carry_out
);

  logic w_nb, w_t0, w_t1, w_t2;

  not `SUB_GATE_DLY g_inv  (w_nb, b);
  xor `SUB_GATE_DLY g_sum  (d, a, w_nb, carry_in);
  and `SUB_GATE_DLY g_and0 (w_t0, a, w_nb);
  and `SUB_GATE_DLY g_and1 (w_t1, a, carry_in);
  and `SUB_GATE_DLY g_and2 (w_t2, w_nb, carry_in);
  or  `SUB_GATE_DLY g_maj  (carry_out, w_t0, w_t1, w_t2);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock with start/ready/done handshake.
// Result registers change only on the transition into DONE and hold otherwise.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrowout,
  output logic             overflow,
  output logic             done
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_sh, r_diff;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry, r_sa, r_sb;
  logic             r_borrow, r_ovf, r_done;
  logic             w_d, w_cout;

  serial_sub_cell u_cell (
    .a         (r_a[0]),
    .b         (r_b[0]),
    .carry_in  (r_carry),
    .d         (w_d),
    .carry_out (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sh     <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b1;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_RUN;
            r_a     <= a;
            r_b     <= b;
            r_sa    <= a[WIDTH-1];
            r_sb    <= b[WIDTH-1];
            r_carry <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_sh    <= {w_d, r_sh[WIDTH-1:1]};
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            // w_d is the sign bit of the result on this final edge
            r_state  <= S_DONE;
            r_diff   <= {w_d, r_sh[WIDTH-1:1]};
            r_borrow <= ~w_cout;
            r_ovf    <= (r_sa != r_sb) && (w_d != r_sa);
            r_done   <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready     = (r_state == S_IDLE) || (r_state == S_DONE);
  assign diff      = r_diff;
  assign borrowout = r_borrow;
  assign overflow  = r_ovf;
  assign done      = r_done;

endmodule
